fpu_addsub_pipe: RTL and testbench

//  Parametrised successor of the tinyZuse floating-point add/sub unit.
//  - Adds a sign bit, generic exponent/mantissa widths, a start/done handshake and fixed latency.
//  - Adds normalisation on both paths, plus zero, overflow and underflow handling.
//  - Sits between the register file (R1/R2) and the result register, driven by the control FSM.

---
 rtl/fpu_addsub_pipe.sv | 148 ++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// Pipelined-by-state floating-point add/sub: sign/exponent/mantissa operands,
// start/done handshake, fixed five-state sequence with normalisation and range checks.
module fpu_addsub_pipe #(
  parameter int unsigned EXP_W = 7,
  parameter int unsigned MAN_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             a_s,
  input  logic [EXP_W-1:0] a_e,
  input  logic [MAN_W-1:0] a_m,
  input  logic             b_s,
  input  logic [EXP_W-1:0] b_e,
  input  logic [MAN_W-1:0] b_m,
  output logic             res_s,
  output logic [EXP_W-1:0] res_e,
  output logic [MAN_W-1:0] res_m,
  output logic             ovf,
  output logic             unf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned XE_W = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(MAN_W + 1);
  localparam logic signed [EXP_W:0]  MAN_W_S = (EXP_W+1)'(MAN_W);
  localparam logic signed [XE_W-1:0] E_MAX   = XE_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XE_W-1:0] E_MIN   = -E_MAX - XE_W'(1);

  typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, NORM} state_t;

  state_t             state_q;
  logic               op_q, as_q, bs_q;
  logic [EXP_W-1:0]   ae_q, be_q;
  logic [MAN_W-1:0]   am_q, bm_q;
  logic               eff_q, rs_q;
  logic [EXP_W-1:0]   le_q, se_q;
  logic [MAN_W-1:0]   lm_q, sm_q;
  logic [MAN_W:0]     sum_q;

  logic               a_ge, pick_b;
  logic signed [EXP_W:0]  d;
  logic [MAN_W-1:0]   sm_al;
  logic [MAN_W:0]     sum_c;
  logic [LZ_W-1:0]    lz;
  logic signed [XE_W-1:0] e_l, norm_e;
  logic [MAN_W-1:0]   norm_m;

  // Operand ordering: a zero mantissa always loses; ties keep A as the larger one.
  always_comb begin
    a_ge = ($signed(ae_q) > $signed(be_q)) || ((ae_q == be_q) && (am_q >= bm_q));
    if (bm_q == '0)      pick_b = 1'b0;
    else if (am_q == '0) pick_b = 1'b1;
    else                 pick_b = !a_ge;
  end

  // Alignment; a negative gap only arises when S is a zero operand, so clearing is safe.
  always_comb begin
    d = $signed({le_q[EXP_W-1], le_q}) - $signed({se_q[EXP_W-1], se_q});
    if (d[EXP_W] || (d >= MAN_W_S)) sm_al = '0;
    else                            sm_al = sm_q >> d;
    sum_c = eff_q ? ({1'b0, lm_q} - {1'b0, sm_q}) : ({1'b0, lm_q} + {1'b0, sm_q});
  end

  // Normalisation: carry shifts right on the add path, leading-zero count on the sub path.
  always_comb begin
    lz = '0;
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (sum_q[i]) lz = LZ_W'(int'(MAN_W) - 1 - i);
    end
    e_l = $signed({{2{le_q[EXP_W-1]}}, le_q});
    if (!eff_q && sum_q[MAN_W]) begin
      norm_m = sum_q[MAN_W:1];
      norm_e = e_l + XE_W'(1);
    end else if (eff_q) begin
      norm_m = sum_q[MAN_W-1:0] << lz;
      norm_e = e_l - $signed(XE_W'(lz));
    end else begin
      norm_m = sum_q[MAN_W-1:0];
      norm_e = e_l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= 1'b0; as_q <= 1'b0; bs_q <= 1'b0;
      ae_q <= '0; be_q <= '0; am_q <= '0; bm_q <= '0;
      eff_q <= 1'b0; rs_q <= 1'b0;
      le_q <= '0; se_q <= '0; lm_q <= '0; sm_q <= '0;
      sum_q <= '0;
      res_s <= 1'b0; res_e <= '0; res_m <= '0;
      ovf <= 1'b0; unf <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= op_sub;
            as_q <= a_s; ae_q <= a_e; am_q <= a_m;
            bs_q <= b_s; be_q <= b_e; bm_q <= b_m;
            busy <= 1'b1;
            state_q <= SWAP;
          end
        end
        SWAP: begin
          eff_q <= op_q ^ as_q ^ bs_q;
          rs_q  <= pick_b ? (bs_q ^ op_q) : as_q;
          le_q  <= pick_b ? be_q : ae_q;
          lm_q  <= pick_b ? bm_q : am_q;
          se_q  <= pick_b ? ae_q : be_q;
          sm_q  <= pick_b ? am_q : bm_q;
          state_q <= ALIGN;
        end
        ALIGN: begin
          sm_q <= sm_al;
          state_q <= ADD;
        end
        ADD: begin
          sum_q <= sum_c;
          state_q <= NORM;
        end
        NORM: begin
          ovf <= 1'b0;
          unf <= 1'b0;
          if (sum_q == '0) begin
            res_s <= 1'b0; res_e <= '0; res_m <= '0;
          end else if (norm_e > E_MAX) begin
            ovf <= 1'b1;
            res_s <= rs_q; res_e <= E_MAX[EXP_W-1:0]; res_m <= '1;
          end else if (norm_e < E_MIN) begin
            unf <= 1'b1;
            res_s <= 1'b0; res_e <= '0; res_m <= '0;
          end else begin
            res_s <= rs_q; res_e <= norm_e[EXP_W-1:0]; res_m <= norm_m;
          end
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Self-checking bench for fpu_addsub_pipe: directed vector table, randomized
// operations against an arithmetic reference model, and handshake/reset sequences.
module tb_fpu_addsub_pipe;

  localparam int EXP_W = 7;
  localparam int MAN_W = 15;
  localparam int EMAX  = 63;
  localparam int EMIN  = -64;

  logic clk, rst_n, start, op_sub, a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e, res_e;
  logic [MAN_W-1:0] a_m, b_m, res_m;
  logic res_s, ovf, unf, busy, done;

  int tests, fails;

  fpu_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a_s(a_s), .a_e(a_e), .a_m(a_m), .b_s(b_s), .b_e(b_e), .b_m(b_m),
    .res_s(res_s), .res_e(res_e), .res_m(res_m),
    .ovf(ovf), .unf(unf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic op; logic as; logic [6:0] ae; logic [14:0] am;
    logic bs; logic [6:0] be; logic [14:0] bm;
    logic [24:0] exp;
  } vec_t;

  function automatic logic [24:0] pack(logic s, logic [6:0] e, logic [14:0] m, logic o, logic u);
    return {s, e, m, o, u};
  endfunction

  function automatic logic [24:0] got_now();
    return {res_s, res_e, res_m, ovf, unf};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Reference: value arithmetic on integers, normalised by plain loops.
  function automatic logic [24:0] model(logic op, logic as, logic [6:0] ae, logic [14:0] am,
                                        logic bs, logic [6:0] be, logic [14:0] bm);
    int ea, eb, le, se, lm, sm, d, sum, e, m;
    logic sign, eff, pb;
    ea = int'($signed(ae));
    eb = int'($signed(be));
    if (bm == 0)      pb = 1'b0;
    else if (am == 0) pb = 1'b1;
    else              pb = (eb > ea) || (eb == ea && bm > am);
    le = pb ? eb : ea;  lm = pb ? int'(bm) : int'(am);
    se = pb ? ea : eb;  sm = pb ? int'(am) : int'(bm);
    sign = pb ? (bs ^ op) : as;
    eff = op ^ as ^ bs;
    d = le - se;
    sm = (d < 0 || d >= MAN_W) ? 0 : (sm >> d);
    sum = eff ? lm - sm : lm + sm;
    if (sum == 0) return '0;
    e = le; m = sum;
    while (m >= (1 << MAN_W)) begin m = m >> 1; e++; end
    while (m < (1 << (MAN_W - 1))) begin m = m << 1; e--; end
    if (e > EMAX) return pack(sign, 7'h3F, 15'h7FFF, 1'b1, 1'b0);
    if (e < EMIN) return pack(1'b0, 7'h00, 15'h0000, 1'b0, 1'b1);
    return pack(sign, 7'(e), 15'(m), 1'b0, 1'b0);
  endfunction

  task automatic drive(input logic op, input logic as, input logic [6:0] ae, input logic [14:0] am,
                       input logic bs, input logic [6:0] be, input logic [14:0] bm);
    op_sub = op; a_s = as; a_e = ae; a_m = am; b_s = bs; b_e = be; b_m = bm;
    start = 1'b1;
  endtask

  // Capture edge, then count edges until done; bounded.
  task automatic wait_done(input string name, output logic [24:0] got, output int lat);
    lat = 0;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!done) check({name, "_timeout"}, 32'(lat), 32'd4);
    got = got_now();
  endtask

  vec_t tbl[14];
  logic [24:0] got, exp;
  int lat, ndone;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0;
    drive(1'b0, 1'b0, 7'h0, 15'h0, 1'b0, 7'h0, 15'h0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {got_now(), busy, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {got_now(), busy, done}, 32'd0);

    tbl[0]  = '{1'b0, 1'b0, 7'h00, 15'h4000, 1'b0, 7'h00, 15'h4000, pack(0, 7'h01, 15'h4000, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, 7'h00, 15'h6000, 1'b0, 7'h00, 15'h4000, pack(0, 7'h7F, 15'h4000, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 7'h05, 15'h5A5A, 1'b0, 7'h05, 15'h5A5A, pack(0, 7'h00, 15'h0000, 0, 0)};
    tbl[3]  = '{1'b1, 1'b0, 7'h00, 15'h4000, 1'b0, 7'h00, 15'h6000, pack(1, 7'h7F, 15'h4000, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, 7'h3F, 15'h7FFF, 1'b0, 7'h3F, 15'h7FFF, pack(0, 7'h3F, 15'h7FFF, 1, 0)};
    tbl[5]  = '{1'b1, 1'b0, 7'h40, 15'h4001, 1'b0, 7'h40, 15'h4000, pack(0, 7'h00, 15'h0000, 0, 1)};
    tbl[6]  = '{1'b0, 1'b0, 7'h14, 15'h4000, 1'b0, 7'h00, 15'h7FFF, pack(0, 7'h14, 15'h4000, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 7'h00, 15'h5555, 1'b1, 7'h14, 15'h4000, pack(0, 7'h14, 15'h4000, 0, 0)};
    tbl[8]  = '{1'b1, 1'b0, 7'h03, 15'h0000, 1'b0, 7'h02, 15'h5000, pack(1, 7'h02, 15'h5000, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, 7'h05, 15'h0000, 1'b0, 7'h09, 15'h0000, pack(0, 7'h00, 15'h0000, 0, 0)};
    tbl[10] = '{1'b0, 1'b0, 7'h0E, 15'h4000, 1'b0, 7'h00, 15'h7FFF, pack(0, 7'h0E, 15'h4001, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, 7'h0F, 15'h4000, 1'b0, 7'h00, 15'h7FFF, pack(0, 7'h0F, 15'h4000, 0, 0)};
    tbl[12] = '{1'b1, 1'b0, 7'h01, 15'h4000, 1'b0, 7'h00, 15'h4000, pack(0, 7'h00, 15'h4000, 0, 0)};
    tbl[13] = '{1'b0, 1'b1, 7'h7E, 15'h4000, 1'b1, 7'h7E, 15'h4000, pack(1, 7'h7F, 15'h4000, 0, 0)};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].as, tbl[i].ae, tbl[i].am, tbl[i].bs, tbl[i].be, tbl[i].bm);
      wait_done($sformatf("vec%0d", i), got, lat);
      check($sformatf("vec%0d_result", i), 32'(got), 32'(tbl[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_busy_drop", i), 32'(busy), 32'd0);
    end

    // Randomized operations; exponents often kept close to exercise cancellation.
    for (int i = 0; i < 300; i++) begin
      logic op, as, bs;
      logic [6:0] ae, be;
      logic [14:0] am, bm;
      op = 1'($urandom); as = 1'($urandom); bs = 1'($urandom);
      ae = 7'($urandom);
      be = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(ae + 7'($urandom_range(0, 4)) - 7'd2);
      am = 15'h4000 | 15'($urandom_range(0, 16383));
      bm = ($urandom_range(0, 3) == 0) ? 15'(am ^ 15'($urandom_range(0, 15))) | 15'h4000
                                       : 15'h4000 | 15'($urandom_range(0, 16383));
      if ($urandom_range(0, 19) == 0) am = '0;
      if ($urandom_range(0, 19) == 0) bm = '0;
      @(negedge clk);
      drive(op, as, ae, am, bs, be, bm);
      wait_done("rand", got, lat);
      exp = model(op, as, ae, am, bs, be, bm);
      check($sformatf("rand%0d a=%h_%h_%h b=%h_%h_%h op=%b", i, as, ae, am, bs, be, bm, op),
            32'(got), 32'(exp));
    end

    // start held while busy: exactly one done, carrying the first operation's result.
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 15'h4000, 1'b0, 7'h00, 15'h4000);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 7'h05, 15'h7000, 1'b0, 7'h02, 15'h4000);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    got = '0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) begin ndone++; got = got_now(); end
    end
    check("busy_ignore_count", 32'(ndone), 32'd1);
    check("busy_ignore_result", 32'(got), 32'(pack(0, 7'h01, 15'h4000, 0, 0)));

    // Reset while in ALIGN: immediate abort, outputs cleared, no done afterwards.
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h03, 15'h4000, 1'b0, 7'h01, 15'h4000);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_busy", 32'(busy), 32'd0);
    check("abort_outputs", {got_now(), done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Back-to-back: start presented in the done cycle is accepted.
    @(negedge clk);
    drive(1'b1, 1'b0, 7'h00, 15'h6000, 1'b0, 7'h00, 15'h4000);
    wait_done("b2b_first", got, lat);
    check("b2b_first_result", 32'(got), 32'(pack(0, 7'h7F, 15'h4000, 0, 0)));
    drive(1'b0, 1'b1, 7'h02, 15'h4000, 1'b1, 7'h02, 15'h4000);
    wait_done("b2b_second", got, lat);
    check("b2b_second_result", 32'(got), 32'(pack(1, 7'h03, 15'h4000, 0, 0)));
    check("b2b_second_latency", 32'(lat), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
